// File: rtl/cpu_pkg.sv
// Types and constants shared between the boot loader and the CPU instruction path.
package cpu_pkg;

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } loader_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_ram.sv
// Instruction RAM: one synchronous write port for the loader, one asynchronous read port for the CPU.
module instr_ram #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a byte stream into instruction RAM, verifies an XOR checksum,
// then releases the CPU and serves instructions combinationally.
//
//   state  | meaning
//   CNT_LO | waiting for word-count low byte
//   CNT_HI | waiting for word-count high byte, size check
//   DATA   | assembling little-endian words into RAM
//   CSUM   | comparing checksum byte with running XOR
//   RUN    | verified program present, CPU released
//   ERROR  | size or checksum failure, waiting for Reload
module imem_loader
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  ByteData,
    input  logic        ByteValid,
    output logic        ByteReady,
    input  logic        Reload,
    input  logic [31:0] InstructionAddr,
    output logic [31:0] Instruction,
    output logic        CpuRun,
    output logic        Loading,
    output logic        LoadError,
    output logic [15:0] WordCount
);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [15:0] r_word_count;
    logic [15:0] r_ptr;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic [7:0]  r_xor;

    logic          w_accept;
    logic          w_we;
    logic          w_last_word;
    logic          w_oversize;
    logic [15:0]   w_count_full;
    logic [31:0]   w_wr_data;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_rd_data;
    logic          w_addr_hi_zero;
    logic          w_in_range;
    logic          w_unused_addr_lsb;

    // Reload takes priority, so a byte offered in the same cycle is not consumed.
    assign w_accept     = ByteValid && ByteReady && !Reload;
    assign w_count_full = {ByteData, r_word_count[7:0]};
    assign w_oversize   = {1'b0, w_count_full} > 17'(DEPTH);
    assign w_last_word  = (r_ptr == (r_word_count - 16'd1));
    assign w_we         = w_accept && (r_state == DATA) && (r_byte_cnt == 2'd3);
    assign w_wr_data    = {ByteData, r_shift};

    always_comb begin
        w_next    = r_state;
        ByteReady = 1'b0;
        Loading   = 1'b0;
        CpuRun    = 1'b0;
        LoadError = 1'b0;
        case (r_state)
            CNT_LO: begin
                ByteReady = 1'b1;
                Loading   = 1'b1;
                if (w_accept) w_next = CNT_HI;
            end
            CNT_HI: begin
                ByteReady = 1'b1;
                Loading   = 1'b1;
                if (w_accept) begin
                    if (w_oversize)                 w_next = ERROR;
                    else if (w_count_full == 16'd0) w_next = CSUM;
                    else                            w_next = DATA;
                end
            end
            DATA: begin
                ByteReady = 1'b1;
                Loading   = 1'b1;
                if (w_we && w_last_word) w_next = CSUM;
            end
            CSUM: begin
                ByteReady = 1'b1;
                Loading   = 1'b1;
                if (w_accept) w_next = (ByteData == r_xor) ? RUN : ERROR;
            end
            RUN:     CpuRun    = 1'b1;
            ERROR:   LoadError = 1'b1;
            default: w_next    = CNT_LO;
        endcase
        if (Reload) w_next = CNT_LO;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= CNT_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_word_count <= 16'd0;
            r_ptr        <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_xor        <= 8'd0;
        end else if (Reload) begin
            r_ptr        <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_xor        <= 8'd0;
        end else if (w_accept) begin
            case (r_state)
                CNT_LO: r_word_count[7:0]  <= ByteData;
                CNT_HI: r_word_count[15:8] <= ByteData;
                DATA: begin
                    r_xor      <= r_xor ^ ByteData;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        r_ptr <= r_ptr + 16'd1;
                    end else begin
                        r_shift <= {ByteData, r_shift[23:8]};
                    end
                end
                default: ;
            endcase
        end
    end

    instr_ram #(
        .DEPTH (DEPTH)
    ) u_instr_ram (
        .Clk     (Clk),
        .i_we    (w_we),
        .i_waddr (r_ptr[AW-1:0]),
        .i_wdata (w_wr_data),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    // Byte-offset bits are irrelevant for word-aligned fetch.
    assign w_unused_addr_lsb = ^InstructionAddr[1:0];
    assign w_rd_idx          = InstructionAddr[AW+1:2];
    assign w_addr_hi_zero    = (InstructionAddr[31:AW+2] == '0);
    assign w_in_range        = 32'(w_rd_idx) < 32'(r_word_count);
    assign Instruction       = (CpuRun && w_addr_hi_zero && w_in_range) ? w_rd_data : NOP_INSTR;
    assign WordCount         = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a word-level model of the loaded image.
module tb_imem_loader;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  ByteData;
    logic        ByteValid;
    logic        ByteReady;
    logic        Reload;
    logic [31:0] InstructionAddr;
    logic [31:0] Instruction;
    logic        CpuRun;
    logic        Loading;
    logic        LoadError;
    logic [15:0] WordCount;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .ByteData        (ByteData),
        .ByteValid       (ByteValid),
        .ByteReady       (ByteReady),
        .Reload          (Reload),
        .InstructionAddr (InstructionAddr),
        .Instruction     (Instruction),
        .CpuRun          (CpuRun),
        .Loading         (Loading),
        .LoadError       (LoadError),
        .WordCount       (WordCount)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_mem [DEPTH];
    int          m_count = 0;
    bit          m_run = 1'b0;
    logic [31:0] stim_words [DEPTH];

    function automatic logic [31:0] model_instr(input logic [31:0] addr);
        int idx;
        if (!m_run) return 32'h0;
        if ((addr >> (AW + 2)) != 32'h0) return 32'h0;
        idx = int'(addr[AW+1:2]);
        if (idx >= m_count) return 32'h0;
        return m_mem[idx];
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                ByteData  = 8'($urandom);
                ByteValid = 1'b0;
                @(posedge Clk); #1;
            end
        end
        ByteData  = b;
        ByteValid = 1'b1;
        @(posedge Clk); #1;
        ByteValid = 1'b0;
        ByteData  = 8'($urandom);
    endtask

    task automatic load_stream(input int cnt, input logic [7:0] mask, input bit gaps);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] c;
        x = 8'h00;
        c = 16'(cnt);
        send_byte(c[7:0], gaps);
        send_byte(c[15:8], gaps);
        m_count = cnt;
        m_run   = 1'b0;
        if (cnt > DEPTH) return;
        for (int i = 0; i < cnt; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = stim_words[i][8*k +: 8];
                x = x ^ b;
                send_byte(b, gaps);
            end
            m_mem[i] = stim_words[i];
        end
        send_byte(x ^ mask, gaps);
        m_run = (mask == 8'h00);
    endtask

    task automatic do_reload();
        Reload = 1'b1;
        @(posedge Clk); #1;
        Reload = 1'b0;
        m_run  = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0; Reload = 1'b0; ByteValid = 1'b0; ByteData = 8'h00; InstructionAddr = 32'h0;
        @(posedge Clk); #1;
        n_checks++; if (ByteReady !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b expected 1", ByteReady); end
        n_checks++; if (CpuRun !== 1'b0) begin n_errors++; $display("FAIL rst_run: got %b expected 0", CpuRun); end
        n_checks++; if (Loading !== 1'b1) begin n_errors++; $display("FAIL rst_loading: got %b expected 1", Loading); end
        n_checks++; if (LoadError !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", LoadError); end
        n_checks++; if (WordCount !== 16'h0) begin n_errors++; $display("FAIL rst_count: got %h expected 0", WordCount); end
        n_checks++; if (Instruction !== 32'h0) begin n_errors++; $display("FAIL rst_instr: got %h expected 0", Instruction); end
        Rst = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0]  bytes [11];
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        bytes = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h48, 8'h00, 8'h01, 8'h44};
        addrs = '{32'h0, 32'h4, 32'h8, 32'h6, 32'h40};
        exps  = '{32'h2008_0005, 32'h0100_4820, 32'h0, 32'h0100_4820, 32'h0};
        for (int i = 0; i < 10; i++) send_byte(bytes[i], 1'b0);
        n_checks++; if (CpuRun !== 1'b0 || Loading !== 1'b1) begin n_errors++; $display("FAIL basic_pre_csum: got run=%b loading=%b expected run=0 loading=1", CpuRun, Loading); end
        send_byte(bytes[10], 1'b0);
        n_checks++; if (CpuRun !== 1'b1) begin n_errors++; $display("FAIL basic_run: got %b expected 1", CpuRun); end
        n_checks++; if (ByteReady !== 1'b0 || Loading !== 1'b0) begin n_errors++; $display("FAIL basic_idle: got ready=%b loading=%b expected 0 0", ByteReady, Loading); end
        n_checks++; if (WordCount !== 16'd2) begin n_errors++; $display("FAIL basic_count: got %0d expected 2", WordCount); end
        for (int i = 0; i < 5; i++) begin
            InstructionAddr = addrs[i]; #1;
            n_checks++; if (Instruction !== exps[i]) begin n_errors++; $display("FAIL basic_read addr=%h: got %h expected %h", addrs[i], Instruction, exps[i]); end
        end
        m_mem[0] = 32'h2008_0005; m_mem[1] = 32'h0100_4820; m_count = 2; m_run = 1'b1;
    endtask

    task automatic test_bad_csum();
        do_reload();
        n_checks++; if (CpuRun !== 1'b0 || ByteReady !== 1'b1) begin n_errors++; $display("FAIL reload_run: got run=%b ready=%b expected 0 1", CpuRun, ByteReady); end
        stim_words[0] = 32'h2008_0005; stim_words[1] = 32'h0100_4820;
        load_stream(2, 8'h01, 1'b0);
        n_checks++; if (LoadError !== 1'b1 || CpuRun !== 1'b0) begin n_errors++; $display("FAIL badcsum_state: got err=%b run=%b expected 1 0", LoadError, CpuRun); end
        for (int a = 0; a < 4; a++) begin
            InstructionAddr = 32'(a * 4); #1;
            n_checks++; if (Instruction !== 32'h0) begin n_errors++; $display("FAIL badcsum_read addr=%h: got %h expected 0", InstructionAddr, Instruction); end
        end
    endtask

    task automatic test_oversize();
        do_reload();
        load_stream(DEPTH + 1, 8'h00, 1'b0);
        n_checks++; if (LoadError !== 1'b1 || ByteReady !== 1'b0) begin n_errors++; $display("FAIL oversize: got err=%b ready=%b expected 1 0", LoadError, ByteReady); end
        do_reload();
        n_checks++; if (LoadError !== 1'b0 || ByteReady !== 1'b1) begin n_errors++; $display("FAIL oversize_reload: got err=%b ready=%b expected 0 1", LoadError, ByteReady); end
    endtask

    task automatic test_zero();
        load_stream(0, 8'h00, 1'b0);
        n_checks++; if (CpuRun !== 1'b1 || WordCount !== 16'd0) begin n_errors++; $display("FAIL zero_run: got run=%b count=%0d expected 1 0", CpuRun, WordCount); end
        for (int a = 0; a < 4; a++) begin
            InstructionAddr = 32'(a * 4); #1;
            n_checks++; if (Instruction !== 32'h0) begin n_errors++; $display("FAIL zero_read addr=%h: got %h expected 0", InstructionAddr, Instruction); end
        end
    endtask

    task automatic test_random_gaps();
        int cnt;
        for (int it = 0; it < 4; it++) begin
            cnt = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            for (int i = 0; i < DEPTH; i++) stim_words[i] = $urandom;
            for (int g = 0; g < 2; g++) begin
                do_reload();
                load_stream(cnt, 8'h00, g[0]);
                n_checks++; if (CpuRun !== 1'b1 || WordCount !== 16'(cnt)) begin n_errors++; $display("FAIL rand_run it=%0d gaps=%0d: got run=%b count=%0d expected 1 %0d", it, g, CpuRun, WordCount, cnt); end
                for (int a = 0; a < DEPTH + 3; a++) begin
                    InstructionAddr = 32'(a * 4) | 32'($urandom_range(0, 3));
                    if (a == DEPTH + 2) InstructionAddr = 32'h8000_0000 | 32'($urandom_range(0, 15) * 4);
                    #1;
                    n_checks++; if (Instruction !== model_instr(InstructionAddr)) begin n_errors++; $display("FAIL rand_read addr=%h: got %h expected %h", InstructionAddr, Instruction, model_instr(InstructionAddr)); end
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reload();
        for (int i = 0; i < 3; i++) stim_words[i] = $urandom;
        send_byte(8'h03, 1'b0); send_byte(8'h00, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
        Rst = 1'b0; #2;
        n_checks++; if (Loading !== 1'b1 || CpuRun !== 1'b0 || WordCount !== 16'h0) begin n_errors++; $display("FAIL rst_mid: got loading=%b run=%b count=%0d expected 1 0 0", Loading, CpuRun, WordCount); end
        m_run = 1'b0; m_count = 0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        load_stream(3, 8'h00, 1'b1);
        n_checks++; if (CpuRun !== 1'b1) begin n_errors++; $display("FAIL rst_mid_reload_run: got %b expected 1", CpuRun); end
        for (int a = 0; a < 5; a++) begin
            InstructionAddr = 32'(a * 4); #1;
            n_checks++; if (Instruction !== model_instr(InstructionAddr)) begin n_errors++; $display("FAIL rst_mid_read addr=%h: got %h expected %h", InstructionAddr, Instruction, model_instr(InstructionAddr)); end
        end
    endtask

    task automatic test_reload_coincident();
        do_reload();
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        ByteData = 8'h07; ByteValid = 1'b1; Reload = 1'b1;
        @(posedge Clk); #1;
        ByteValid = 1'b0; Reload = 1'b0; m_run = 1'b0;
        n_checks++; if (Loading !== 1'b1 || ByteReady !== 1'b1 || CpuRun !== 1'b0) begin n_errors++; $display("FAIL reload_coinc: got loading=%b ready=%b run=%b expected 1 1 0", Loading, ByteReady, CpuRun); end
        stim_words[0] = $urandom; stim_words[1] = $urandom;
        load_stream(2, 8'h00, 1'b0);
        n_checks++; if (CpuRun !== 1'b1 || WordCount !== 16'd2) begin n_errors++; $display("FAIL reload_coinc_run: got run=%b count=%0d expected 1 2", CpuRun, WordCount); end
        for (int a = 0; a < 3; a++) begin
            InstructionAddr = 32'(a * 4); #1;
            n_checks++; if (Instruction !== model_instr(InstructionAddr)) begin n_errors++; $display("FAIL reload_coinc_read addr=%h: got %h expected %h", InstructionAddr, Instruction, model_instr(InstructionAddr)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_oversize();
        test_zero();
        test_random_gaps();
        test_rst_mid();
        test_reload_coincident();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory and loader sitting directly upstream of the CPU's instruction port. Receives a program as a handshaked byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words into an internal instruction RAM and verifies an XOR checksum. On success it releases the CPU via `CpuRun`, then serves `Instruction` combinationally from `InstructionAddr`. The CPU is held in reset (`Rst` gated with `CpuRun` at top level) whenever no verified program is loaded.

## Interface
Parameters:
- `DEPTH`, 256: instruction RAM size in 32-bit words; power of two, 2..65536.
- `AW`, `$clog2(DEPTH)`: word-address width; derived, not overridden.

Ports:
- `Clk` input 1: single clock; all state on rising edge.
- `Rst` input 1: asynchronous, active-low reset.
- `ByteData` input 8: stream byte.
- `ByteValid` input 1: `ByteData` valid.
- `ByteReady` output 1: loader can accept a byte this cycle.
- `Reload` input 1: single-cycle request to discard the program and accept a new stream.
- `InstructionAddr` input 32: byte address from CPU PC.
- `Instruction` output 32: instruction word for `InstructionAddr`.
- `CpuRun` output 1: verified program present; CPU may execute.
- `Loading` output 1: stream in progress.
- `LoadError` output 1: last load failed (size or checksum).
- `WordCount` output 16: word count of the current/last stream.

## Operation
- Byte accepted when `ByteValid && ByteReady`. `ByteReady` = 1 in CNT_LO, CNT_HI, DATA, CSUM; 0 in RUN, ERROR.
- Stream format: count low byte, count high byte, `count`×4 data bytes (each word little-endian, byte 0 = bits 7:0), one checksum byte = XOR of all data bytes (count bytes excluded).
- States (shared enum):
  - CNT_LO: accept → `WordCount[7:0]`, → CNT_HI.
  - CNT_HI: accept → `WordCount[15:8]`; if count > `DEPTH` → ERROR; if count = 0 → CSUM; else → DATA.
  - DATA: byte counter 0..3 fills word shift register, running XOR updated; on 4th byte write word to RAM at word pointer, pointer+1; after word `count-1` → CSUM.
  - CSUM: accept; equal to running XOR → RUN, else → ERROR.
  - RUN: `CpuRun`=1. ERROR: `LoadError`=1.
- `Reload` in any state: → CNT_LO, clears pointer, byte counter, running XOR, `LoadError`; `Reload` wins over a simultaneous byte accept (byte dropped, not consumed). RAM contents are not cleared.
- Read: word index = `InstructionAddr[AW+1:2]`; bits 1:0 ignored. `Instruction` = RAM word if `CpuRun`=1, `InstructionAddr[31:AW+2]`=0 and index < `WordCount`; otherwise 32'h0000_0000 (NOP).
- `Loading` = 1 in CNT_LO..CSUM.

## Timing
- Reset values: state CNT_LO, `ByteReady`=1, `CpuRun`=0, `Loading`=1, `LoadError`=0, `WordCount`=0, `Instruction`=0; pointer, byte counter, XOR = 0.
- RAM write occurs on the edge accepting a word's 4th byte; word is readable from the next cycle.
- `CpuRun`/`LoadError` assert on the cycle after the checksum byte (or oversize count byte) is accepted.
- `Reload` asserted at edge N: `CpuRun` low, `ByteReady` high from cycle N+1.
- Read path is combinational (zero latency), matching the single-cycle CPU.
- Throughput: one byte per cycle with no bubbles.

## Structure
- Shared package `cpu_pkg`: `loader_state_t` enum (CNT_LO, CNT_HI, DATA, CSUM, RUN, ERROR), `NOP_INSTR` = 32'h0.
- Sub-module `instr_ram`: `DEPTH`×32, synchronous write port, asynchronous read port. FSM, assembly and checksum logic in `imem_loader`.

## Test plan
- Load count=2, words 32'h2008_0005, 32'h0100_4820 (bytes 02 00 05 00 08 20 20 48 00 01 …), correct XOR → `CpuRun`=1 one cycle after CSUM; addr 0 → 32'h2008_0005, addr 4 → 32'h0100_4820, addr 8 → 0, addr 6 → 32'h0100_4820.
- Same stream, checksum XOR'd with 8'h01 → `LoadError`=1, `CpuRun`=0, `Instruction`=0 at all addresses.
- Count = `DEPTH`+1 → ERROR after 2nd byte, `ByteReady`=0; then `Reload` pulse → `ByteReady`=1, `LoadError`=0.
- Count=0, checksum 8'h00 → RUN; every address returns 0.
- `ByteValid` toggled randomly during DATA → identical RAM contents and result as back-to-back stream.
- `Rst` low mid-DATA, and `Reload` coincident with a data byte → CNT_LO, byte not consumed; a full new stream then loads correctly.
